// File: rtl/bram_bank_pkg.sv
// Shared constants for the banked BRAM read crossbar.
package bram_bank_pkg;

    // Cycles from read grant to response valid.
    localparam int unsigned RD_LATENCY = 2;

    // Bank-select width: at least one bit, even with a single bank.
    function automatic int unsigned bank_sel_width(input int unsigned nb_banks);
        return (nb_banks > 1) ? int'($clog2(nb_banks)) : 1;
    endfunction

endpackage

// File: rtl/Bram.sv
// Simple dual-port block RAM with a registered, read-first read port.
module Bram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  wrclk,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic                  rdclk,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] rddata
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rddata;

    // Write port; storage is never reset.
    always_ff @(posedge wrclk) begin
        if (wren) begin
            r_mem[wraddr] <= wrdata;
        end
    end

    // Read port; a same-cycle write to the same word is not yet visible (read-first).
    always_ff @(posedge rdclk) begin
        if (rden) begin
            r_rddata <= r_mem[rdaddr];
        end
    end

    assign rddata = r_rddata;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the agent after the last winner has top priority.
module rr_arbiter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_grant
);

    localparam int unsigned PW = (WIDTH > 1) ? int'($clog2(WIDTH)) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    // Scan requesters starting at the pointer, grant the first one found.
    always_comb begin
        int unsigned idx;
        o_grant    = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = 32'(r_ptr) + i;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            if (!w_found && i_req[idx]) begin
                w_found      = 1'b1;
                o_grant[idx] = 1'b1;
                w_next_ptr   = (idx + 1 >= WIDTH) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Pointer moves past the winner; holds when nobody is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/bram_bank_xbar.sv
// Banked BRAM crossbar: one bank per write agent, any read agent can read any bank.
module bram_bank_xbar
    import bram_bank_pkg::*;
#(
    parameter  int unsigned NB_WRAGENT = 2,
    parameter  int unsigned NB_RDAGENT = 2,
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned BANK_WIDTH = bank_sel_width(NB_WRAGENT)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] wrdata,
    input  logic [NB_RDAGENT-1:0]            rdvalid,
    output logic [NB_RDAGENT-1:0]            rdready,
    input  logic [BANK_WIDTH*NB_RDAGENT-1:0] rdbank,
    input  logic [ADDR_WIDTH*NB_RDAGENT-1:0] rdaddr,
    output logic [NB_RDAGENT-1:0]            rspvalid,
    input  logic [NB_RDAGENT-1:0]            rspready,
    output logic [DATA_WIDTH*NB_RDAGENT-1:0] rspdata
);

    logic [NB_RDAGENT-1:0]            w_elig;
    logic [NB_RDAGENT-1:0]            w_oor_grant;
    logic [NB_WRAGENT*NB_RDAGENT-1:0] w_bank_req;
    logic [NB_WRAGENT*NB_RDAGENT-1:0] w_bank_gnt;
    logic [NB_WRAGENT-1:0]            w_bank_rden;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] w_bank_rdaddr;
    logic [NB_WRAGENT*DATA_WIDTH-1:0] w_bank_rddata;
    logic [DATA_WIDTH-1:0]            w_rsp_word [NB_RDAGENT];

    logic [NB_RDAGENT-1:0]            r_inflight;
    logic [BANK_WIDTH-1:0]            r_inflight_bank [NB_RDAGENT];
    logic [NB_RDAGENT-1:0]            r_rspvalid;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] r_rspdata;

    // Eligibility and request routing to the per-bank arbiters; out-of-range banks bypass arbitration.
    always_comb begin
        w_elig      = '0;
        w_oor_grant = '0;
        w_bank_req  = '0;
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            w_elig[j] = aresetn && !r_inflight[j] && (!r_rspvalid[j] || rspready[j]);
            if (rdvalid[j] && w_elig[j]) begin
                if (32'(rdbank[j*BANK_WIDTH +: BANK_WIDTH]) >= NB_WRAGENT) begin
                    w_oor_grant[j] = 1'b1;
                end
                for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
                    if (32'(rdbank[j*BANK_WIDTH +: BANK_WIDTH]) == b) begin
                        w_bank_req[b*NB_RDAGENT + j] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NB_WRAGENT; b++) begin : g_bank
        rr_arbiter #(
            .WIDTH(NB_RDAGENT)
        ) u_arb (
            .i_clk  (aclk),
            .i_rst_n(aresetn),
            .i_req  (w_bank_req[b*NB_RDAGENT +: NB_RDAGENT]),
            .o_grant(w_bank_gnt[b*NB_RDAGENT +: NB_RDAGENT])
        );

        Bram #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .RAM_DEPTH (RAM_DEPTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_ram (
            .wrclk (aclk),
            .wren  (wren[b]),
            .wraddr(wraddr[b*ADDR_WIDTH +: ADDR_WIDTH]),
            .wrdata(wrdata[b*DATA_WIDTH +: DATA_WIDTH]),
            .rdclk (aclk),
            .rden  (w_bank_rden[b]),
            .rdaddr(w_bank_rdaddr[b*ADDR_WIDTH +: ADDR_WIDTH]),
            .rddata(w_bank_rddata[b*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Each bank's read address comes from its (single) granted agent.
    always_comb begin
        w_bank_rden   = '0;
        w_bank_rdaddr = '0;
        for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                if (w_bank_gnt[b*NB_RDAGENT + j]) begin
                    w_bank_rden[b] = 1'b1;
                    w_bank_rdaddr[b*ADDR_WIDTH +: ADDR_WIDTH] = rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    // Combine per-bank grants with the out-of-range fast path.
    always_comb begin
        rdready = w_oor_grant;
        for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                if (w_bank_gnt[b*NB_RDAGENT + j]) begin
                    rdready[j] = 1'b1;
                end
            end
        end
    end

    // Route the RAM output of the bank each agent read; out-of-range banks return zero.
    always_comb begin
        for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
            w_rsp_word[j] = '0;
            for (int unsigned b = 0; b < NB_WRAGENT; b++) begin
                if (32'(r_inflight_bank[j]) == b) begin
                    w_rsp_word[j] = w_bank_rddata[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // In-flight tracking and response holding registers; reset drops outstanding reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_inflight <= '0;
            r_rspvalid <= '0;
            r_rspdata  <= '0;
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                r_inflight_bank[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NB_RDAGENT; j++) begin
                // A grant can only occur with nothing in flight, so the flag lives exactly one cycle.
                r_inflight[j] <= rdready[j];
                if (rdready[j]) begin
                    r_inflight_bank[j] <= rdbank[j*BANK_WIDTH +: BANK_WIDTH];
                end
                if (r_inflight[j]) begin
                    r_rspvalid[j]                         <= 1'b1;
                    r_rspdata[j*DATA_WIDTH +: DATA_WIDTH] <= w_rsp_word[j];
                end else if (rspready[j]) begin
                    r_rspvalid[j] <= 1'b0;
                end
            end
        end
    end

    assign rspvalid = r_rspvalid;
    assign rspdata  = r_rspdata;

endmodule

// File: tb/tb_bram_bank_xbar.sv
// Self-checking bench for bram_bank_xbar (3 banks, 2 read agents).
module tb_bram_bank_xbar;
    import bram_bank_pkg::*;

    localparam int NW = 3;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = 2;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NW-1:0]     wren;
    logic [AW*NW-1:0]  wraddr;
    logic [DW*NW-1:0]  wrdata;
    logic [NR-1:0]     rdvalid;
    logic [NR-1:0]     rdready;
    logic [BW*NR-1:0]  rdbank;
    logic [AW*NR-1:0]  rdaddr;
    logic [NR-1:0]     rspvalid;
    logic [NR-1:0]     rspready;
    logic [DW*NR-1:0]  rspdata;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] mem [NW][2**AW];
    bit            has_txn [NR];
    int            rsp_cyc [NR];
    logic [DW-1:0] txn_data [NR];
    int            rr_next [NW];
    int            cyc = 0;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_vld;
    logic [DW-1:0] exp_data [NR];

    typedef struct {
        int          wr_bank;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic [1:0]  rdv;
        logic [3:0]  rbank;
        logic [15:0] raddr;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_vld;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
    } vec_t;

    vec_t tbl [17];

    bram_bank_xbar #(
        .NB_WRAGENT(NW),
        .NB_RDAGENT(NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wren    (wren),
        .wraddr  (wraddr),
        .wrdata  (wrdata),
        .rdvalid (rdvalid),
        .rdready (rdready),
        .rdbank  (rdbank),
        .rdaddr  (rdaddr),
        .rspvalid(rspvalid),
        .rspready(rspready),
        .rspdata (rspdata)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] fill(input int b, input int a);
        return (32'(b + 1) << 28) | 32'(a);
    endfunction

    function automatic vec_t mk(input int wb, input logic [7:0] wa, input logic [31:0] wd,
                                input logic [1:0] rdv, input logic [3:0] rb, input logic [15:0] ra,
                                input logic [1:0] rdy, input logic [1:0] vld,
                                input logic [31:0] d0, input logic [31:0] d1);
        vec_t v;
        v.wr_bank = wb; v.wr_addr = wa; v.wr_data = wd;
        v.rdv = rdv; v.rbank = rb; v.raddr = ra;
        v.exp_rdy = rdy; v.exp_vld = vld; v.exp_d0 = d0; v.exp_d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        wren     = '0;
        wraddr   = '0;
        wrdata   = '0;
        rdvalid  = '0;
        rdbank   = '0;
        rdaddr   = '0;
        rspready = '1;
    endtask

    // Expected outputs for the current cycle, from transaction timing and round-robin rules.
    task automatic model_expect();
        logic [NR-1:0] elig;
        bit infl, vis;
        int a;
        exp_rdy = '0;
        elig    = '0;
        for (int j = 0; j < NR; j++) begin
            infl        = has_txn[j] && (cyc < rsp_cyc[j]);
            vis         = has_txn[j] && (cyc >= rsp_cyc[j]);
            elig[j]     = aresetn && !infl && (!vis || rspready[j]);
            exp_vld[j]  = aresetn && vis;
            exp_data[j] = (aresetn && vis) ? txn_data[j] : '0;
            if (rdvalid[j] && elig[j] && int'(rdbank[j*BW +: BW]) >= NW) exp_rdy[j] = 1'b1;
        end
        for (int b = 0; b < NW; b++) begin
            for (int k = 0; k < NR; k++) begin
                a = (rr_next[b] + k) % NR;
                if (rdvalid[a] && elig[a] && int'(rdbank[a*BW +: BW]) == b) begin
                    exp_rdy[a] = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_update();
        int bk;
        if (!aresetn) begin
            for (int j = 0; j < NR; j++) has_txn[j] = 1'b0;
            for (int b = 0; b < NW; b++) rr_next[b] = 0;
        end else begin
            for (int j = 0; j < NR; j++) begin
                bk = int'(rdbank[j*BW +: BW]);
                if (has_txn[j] && cyc >= rsp_cyc[j] && rspready[j]) has_txn[j] = 1'b0;
                if (exp_rdy[j]) begin
                    has_txn[j] = 1'b1;
                    rsp_cyc[j] = cyc + int'(RD_LATENCY);
                    txn_data[j] = '0;
                    if (bk < NW) begin
                        txn_data[j] = mem[bk][rdaddr[j*AW +: AW]];
                        rr_next[bk] = (j + 1) % NR;
                    end
                end
            end
        end
        for (int i = 0; i < NW; i++) begin
            if (wren[i]) mem[i][wraddr[i*AW +: AW]] = wrdata[i*DW +: DW];
        end
        cyc++;
    endtask

    task automatic cycle();
        #1;
        model_expect();
        chk("rdready", 64'(rdready), 64'(exp_rdy));
        chk("rspvalid", 64'(rspvalid), 64'(exp_vld));
        for (int j = 0; j < NR; j++) begin
            if (exp_vld[j] || !aresetn)
                chk($sformatf("rspdata%0d", j), 64'(rspdata[j*DW +: DW]), 64'(exp_data[j]));
        end
        @(posedge aclk);
        model_update();
        @(negedge aclk);
    endtask

    initial begin
        int g0, g1, waited;
        logic [31:0] held;

        for (int j = 0; j < NR; j++) begin
            has_txn[j] = 1'b0; rsp_cyc[j] = 0; txn_data[j] = '0;
        end
        for (int b = 0; b < NW; b++) rr_next[b] = 0;

        tbl[0]  = mk( 0, 8'h10, 32'hDEADBEEF, 2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[1]  = mk(-1, 8'h00, 32'h0,        2'b01, 4'h0, 16'h0010, 2'b01, 2'b00, 32'h0, 32'h0);
        tbl[2]  = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[3]  = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0);
        tbl[4]  = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[5]  = mk(-1, 8'h00, 32'h0,        2'b11, 4'h4, 16'h2120, 2'b11, 2'b00, 32'h0, 32'h0);
        tbl[6]  = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[7]  = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b11, 32'h10000020, 32'h20000021);
        tbl[8]  = mk( 2, 8'h05, 32'h1,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[9]  = mk( 2, 8'h05, 32'h2,        2'b01, 4'h2, 16'h0005, 2'b01, 2'b00, 32'h0, 32'h0);
        tbl[10] = mk(-1, 8'h00, 32'h0,        2'b01, 4'h2, 16'h0005, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[11] = mk(-1, 8'h00, 32'h0,        2'b01, 4'h2, 16'h0005, 2'b01, 2'b01, 32'h1, 32'h0);
        tbl[12] = mk(-1, 8'h00, 32'h0,        2'b01, 4'h2, 16'h0005, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[13] = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b01, 32'h2, 32'h0);
        tbl[14] = mk(-1, 8'h00, 32'h0,        2'b10, 4'hC, 16'h0000, 2'b10, 2'b00, 32'h0, 32'h0);
        tbl[15] = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b00, 32'h0, 32'h0);
        tbl[16] = mk(-1, 8'h00, 32'h0,        2'b00, 4'h0, 16'h0000, 2'b00, 2'b10, 32'h0, 32'h0);

        // Reset state
        aresetn = 1'b0;
        idle();
        rdvalid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_rdready", 64'(rdready), 64'd0);
            chk("rst_rspvalid", 64'(rspvalid), 64'd0);
            chk("rst_rspdata", 64'(rspdata), 64'd0);
            cycle();
        end
        idle();
        aresetn = 1'b1;

        // Known contents in every bank
        for (int a = 0; a < 2**AW; a++) begin
            wren = '1;
            for (int b = 0; b < NW; b++) begin
                wraddr[b*AW +: AW] = 8'(a);
                wrdata[b*DW +: DW] = fill(b, a);
            end
            cycle();
        end
        idle();

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            idle();
            if (tbl[i].wr_bank >= 0) begin
                wren[tbl[i].wr_bank] = 1'b1;
                wraddr[tbl[i].wr_bank*AW +: AW] = tbl[i].wr_addr;
                wrdata[tbl[i].wr_bank*DW +: DW] = tbl[i].wr_data;
            end
            rdvalid = tbl[i].rdv;
            rdbank  = tbl[i].rbank;
            rdaddr  = tbl[i].raddr;
            #1;
            chk($sformatf("tbl%0d_rdready", i), 64'(rdready), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_rspvalid", i), 64'(rspvalid), 64'(tbl[i].exp_vld));
            if (tbl[i].exp_vld[0]) chk($sformatf("tbl%0d_rspdata0", i), 64'(rspdata[31:0]), 64'(tbl[i].exp_d0));
            if (tbl[i].exp_vld[1]) chk($sformatf("tbl%0d_rspdata1", i), 64'(rspdata[63:32]), 64'(tbl[i].exp_d1));
            cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // Both agents hammer bank1: grants alternate, nobody starves
        g0 = 0; g1 = 0;
        rdvalid = 2'b11; rdbank = 4'h5; rdaddr = 16'h3130; rspready = 2'b11;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk($sformatf("rr_alt_c%0d", c), 64'(rdready), (c % 2 == 0) ? 64'd1 : 64'd2);
            if (rdready == 2'b01) g0++;
            else if (rdready == 2'b10) g1++;
            cycle();
        end
        chk("rr_fair0", 64'(g0), 64'd8);
        chk("rr_fair1", 64'(g1), 64'd8);
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // Response backpressure on agent0
        rdvalid = 2'b01; rdbank = 4'h0; rdaddr = 16'h0010; rspready = 2'b10;
        #1 chk("bp_grant", 64'(rdready[0]), 64'd1);
        cycle();
        #1 chk("bp_inflight_rdy", 64'(rdready[0]), 64'd0);
        cycle();
        held = rspdata[31:0];
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 64'(rspvalid[0]), 64'd1);
            chk("bp_data", 64'(rspdata[31:0]), 64'hDEADBEEF);
            chk("bp_stable", 64'(rspdata[31:0]), 64'(held));
            chk("bp_rdy", 64'(rdready[0]), 64'd0);
            cycle();
        end
        idle();
        #1;
        chk("bp_release_valid", 64'(rspvalid[0]), 64'd1);
        chk("bp_release_data", 64'(rspdata[31:0]), 64'hDEADBEEF);
        cycle();
        #1 chk("bp_drop", 64'(rspvalid[0]), 64'd0);
        cycle();

        // Reset one cycle after a grant
        rdvalid = 2'b01; rdbank = 4'h0; rdaddr = 16'h0010;
        #1 chk("mid_rst_grant", 64'(rdready), 64'd1);
        cycle();
        idle();
        aresetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("mid_rst_vld", 64'(rspvalid), 64'd0);
            cycle();
        end
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("post_rst_vld", 64'(rspvalid), 64'd0);
            cycle();
        end
        rdvalid = 2'b01; rdbank = 4'h0; rdaddr = 16'h0010;
        #1 chk("post_rst_grant", 64'(rdready), 64'd1);
        cycle();
        idle();
        waited = 0;
        while (!rspvalid[0] && waited < 4) begin
            cycle();
            waited++;
        end
        chk("post_rst_latency", 64'(waited), 64'd1);
        chk("post_rst_data", 64'(rspdata[31:0]), 64'hDEADBEEF);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            wren = 3'($urandom);
            for (int b = 0; b < NW; b++) begin
                wraddr[b*AW +: AW] = 8'($urandom);
                wrdata[b*DW +: DW] = $urandom;
            end
            rdvalid = 2'($urandom);
            rdbank  = 4'($urandom);
            rdaddr  = 16'($urandom);
            for (int j = 0; j < NR; j++) rspready[j] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
